// File: rtl/sha256_w_sched_ctrl_if.sv
// ---------------------------------------------------------------------------
// sha256_w_sched_ctrl_if
// Bundle of the SHA-256 schedule controller's handshake and datapath signals.
//   blk_valid/blk_ready/blk_data  : 512-bit padded block from the front end
//   abort                         : synchronous drop of the current block
//   w_valid/w_ready/w_out/w_idx/w_last : W[t] stream to the round engine
//   sched_we/sched_block/sched_word    : expansion-stage issue and result
// The controller connects through the slave modport.
// The environment (front end, round engine, expansion stage) uses master.
// ---------------------------------------------------------------------------
interface sha256_w_sched_ctrl_if;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         abort;
    logic         w_valid;
    logic         w_ready;
    logic [31:0]  w_out;
    logic [5:0]   w_idx;
    logic         w_last;
    logic         sched_we;
    logic [159:0] sched_block;
    logic [31:0]  sched_word;

    modport slave (
        input  blk_valid, blk_data, abort, w_ready, sched_word,
        output blk_ready, w_valid, w_out, w_idx, w_last, sched_we, sched_block
    );

    modport master (
        output blk_valid, blk_data, abort, w_ready, sched_word,
        input  blk_ready, w_valid, w_out, w_idx, w_last, sched_we, sched_block
    );
endinterface

// File: rtl/sha256_w_sched_ctrl.sv
// ---------------------------------------------------------------------------
// sha256_w_sched_ctrl
// Sequences SHA-256 message-schedule expansion for one 512-bit block at a time.
// It streams W0..W63 and owns the 16-word history that the external registered
// expansion stage draws its operands from.
// Ports:
//   i_clk   : rising-edge clock
//   i_rst   : asynchronous active-high reset
//   io_bus  : sha256_w_sched_ctrl_if.slave, which carries the block handshake,
//             the word stream and the expansion-stage issue/result signals
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | blk_ready=1, waiting for a block; a handshake loads S and sets t=0
// RUN   | w_valid=1, presents W[t]; the accept at t=63 returns to IDLE
// ---------------------------------------------------------------------------
module sha256_w_sched_ctrl (
    input  logic                        i_clk,
    input  logic                        i_rst,
    sha256_w_sched_ctrl_if.slave        io_bus
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [5:0]  r_t;
    logic [31:0] r_s [16];

    logic        w_accept;
    logic        w_hist_mode;
    logic        w_issue;
    logic        w_load;
    logic [31:0] w_v0;
    logic [31:0] w_v1;
    logic [31:0] w_v9;
    logic [31:0] w_v14;

    assign w_accept    = (r_state == ST_RUN) && io_bus.w_ready;
    assign w_load      = (r_state == ST_IDLE) && io_bus.blk_valid && !io_bus.abort;
    // From t=16 on, the newest word lives in sched_word rather than in S.
    assign w_hist_mode = (r_t >= 6'd16);
    assign w_issue     = w_accept && !io_bus.abort && (r_t >= 6'd15) && (r_t <= 6'd62);

    // The virtual window V is S when t<=15 and {S[1..15], sched_word} otherwise.
    // Only the four taps that the expansion stage consumes are built.
    assign w_v0  = w_hist_mode ? r_s[1]  : r_s[0];
    assign w_v1  = w_hist_mode ? r_s[2]  : r_s[1];
    assign w_v9  = w_hist_mode ? r_s[10] : r_s[9];
    assign w_v14 = w_hist_mode ? r_s[15] : r_s[14];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (io_bus.abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (io_bus.blk_valid)             w_state_nxt = ST_RUN;
                ST_RUN:  if (w_accept && (r_t == 6'd63))   w_state_nxt = ST_IDLE;
                default:                                   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        io_bus.blk_ready   = 1'b0;
        io_bus.w_valid     = 1'b0;
        io_bus.w_out       = 32'h0;
        io_bus.w_idx       = 6'd0;
        io_bus.w_last      = 1'b0;
        io_bus.sched_we    = 1'b0;
        io_bus.sched_block = 160'h0;
        case (r_state)
            ST_IDLE: begin
                io_bus.blk_ready = 1'b1;
            end
            ST_RUN: begin
                io_bus.w_valid  = 1'b1;
                io_bus.w_idx    = r_t;
                io_bus.w_last   = (r_t == 6'd63);
                io_bus.w_out    = w_hist_mode ? io_bus.sched_word : r_s[r_t[3:0]];
                io_bus.sched_we = w_issue;
                if (w_issue) begin
                    io_bus.sched_block = {w_v0, w_v1, w_v9, w_v14, 32'h0};
                end
            end
            default: begin
                io_bus.blk_ready = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_t <= 6'd0;
            for (int i = 0; i < 16; i++) r_s[i] <= 32'h0;
        end else if (io_bus.abort) begin
            r_t <= 6'd0;
            for (int i = 0; i < 16; i++) r_s[i] <= 32'h0;
        end else if (w_load) begin
            r_t <= 6'd0;
            for (int i = 0; i < 16; i++) r_s[i] <= io_bus.blk_data[511 - 32*i -: 32];
        end else if (w_accept) begin
            // Wraps to 0 on the t=63 accept, which leaves IDLE with t=0.
            r_t <= r_t + 6'd1;
            if (w_hist_mode) begin
                for (int i = 0; i < 15; i++) r_s[i] <= r_s[i+1];
                r_s[15] <= io_bus.sched_word;
            end
        end
    end

endmodule

// File: tb/tb_sha256_w_sched_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sha256_w_sched_ctrl
// Bench for the SHA-256 schedule controller. The registered expansion stage is
// emulated here, and the expected words come from a direct software
// message-schedule computation.
// ---------------------------------------------------------------------------
module tb_sha256_w_sched_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sha256_w_sched_ctrl_if bus();

    sha256_w_sched_ctrl dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_w   [64];
    logic [31:0] got_w   [64];
    logic [31:0] saved_w [64];
    logic [31:0] r_exp_word;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

    // Expansion stage: registered, updates only when sched_we is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_exp_word <= 32'h0;
        else if (bus.sched_we)
            r_exp_word <= ssig1(bus.sched_block[63:32]) + bus.sched_block[95:64]
                        + ssig0(bus.sched_block[127:96]) + bus.sched_block[159:128];
    end
    assign bus.sched_word = r_exp_word;

    task automatic gen_ref(input logic [511:0] blk);
        for (int i = 0; i < 16; i++) ref_w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++)
            ref_w[i] = ssig1(ref_w[i-2]) + ref_w[i-7] + ssig0(ref_w[i-15]) + ref_w[i-16];
    endtask

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    // Starts just after the block-handshake edge.
    // Returns after the final accept edge, or just after the negedge where t==stop_t,
    // or after the post-abort idle check.
    task automatic stream(input int stall_pct, input int abort_t, input bit abort_stall,
                          input int stop_t, input bit keep_valid, input logic [511:0] next_data,
                          input string tag);
        int t = 0;
        int pulses = 0;
        int cycles = 0;
        bit ab;
        logic exp_we;
        logic [159:0] exp_blk;
        while (t < 64) begin
            @(negedge clk);
            if (cycles == 0) begin
                bus.blk_valid = keep_valid;
                bus.blk_data  = next_data;
            end
            if (t == stop_t) return;
            cycles++;
            if (cycles > 4000) begin
                checks++; errors++;
                $display("FAIL %s_timeout got t=%0d exp 64", tag, t);
                return;
            end
            bus.w_ready = (stall_pct == 0) ? 1'b1 : ($urandom_range(0, 99) >= stall_pct);
            ab = (t == abort_t);
            if (ab) bus.w_ready = !abort_stall;
            bus.abort = ab;
            #1;
            exp_we  = bus.w_ready && !ab && (t >= 15) && (t <= 62);
            exp_blk = '0;
            if (exp_we) exp_blk = {ref_w[t-15], ref_w[t-14], ref_w[t-6], ref_w[t-1], 32'h0};
            checks++;
            if (bus.w_valid !== 1'b1 || bus.blk_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s_run_flags t=%0d got valid=%b ready=%b exp 1 0", tag, t, bus.w_valid, bus.blk_ready);
            end
            checks++;
            if (bus.w_idx !== t[5:0]) begin
                errors++; $display("FAIL %s_w_idx got %0d exp %0d", tag, bus.w_idx, t);
            end
            checks++;
            if (bus.w_out !== ref_w[t]) begin
                errors++; $display("FAIL %s_w_out t=%0d got %h exp %h", tag, t, bus.w_out, ref_w[t]);
            end
            checks++;
            if (bus.w_last !== (t == 63)) begin
                errors++; $display("FAIL %s_w_last t=%0d got %b exp %b", tag, t, bus.w_last, (t == 63));
            end
            checks++;
            if (bus.sched_we !== exp_we) begin
                errors++; $display("FAIL %s_sched_we t=%0d got %b exp %b", tag, t, bus.sched_we, exp_we);
            end
            checks++;
            if (bus.sched_block !== exp_blk) begin
                errors++; $display("FAIL %s_sched_block t=%0d got %h exp %h", tag, t, bus.sched_block, exp_blk);
            end
            got_w[t] = bus.w_out;
            if (bus.sched_we === 1'b1) pulses++;
            @(posedge clk);
            if (ab) begin
                @(negedge clk);
                bus.abort   = 1'b0;
                bus.w_ready = 1'b0;
                #1;
                checks++;
                if (bus.w_valid !== 1'b0 || bus.blk_ready !== 1'b1 || bus.w_idx !== 6'd0 || bus.w_out !== 32'h0) begin
                    errors++;
                    $display("FAIL %s_after_abort got valid=%b ready=%b idx=%0d out=%h exp 0 1 0 0",
                             tag, bus.w_valid, bus.blk_ready, bus.w_idx, bus.w_out);
                end
                return;
            end
            if (bus.w_ready) t++;
        end
        if (abort_t < 0) begin
            checks++;
            if (pulses != 48) begin
                errors++; $display("FAIL %s_we_pulses got %0d exp 48", tag, pulses);
            end
        end
        if (stall_pct == 0) begin
            checks++;
            if (cycles != 64) begin
                errors++; $display("FAIL %s_cycles got %0d exp 64", tag, cycles);
            end
        end
    endtask

    task automatic drive_block(input logic [511:0] blk, input int stall_pct, input int abort_t,
                               input bit abort_stall, input int stop_t, input string tag);
        @(negedge clk);
        bus.blk_valid = 1'b1;
        bus.blk_data  = blk;
        bus.abort     = 1'b0;
        bus.w_ready   = 1'b0;
        gen_ref(blk);
        #1;
        checks++;
        if (bus.blk_ready !== 1'b1 || bus.w_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle got ready=%b valid=%b exp 1 0", tag, bus.blk_ready, bus.w_valid);
        end
        @(posedge clk);
        stream(stall_pct, abort_t, abort_stall, stop_t, 1'b0, 512'h0, tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (bus.blk_ready !== 1'b1 || bus.w_valid !== 1'b0 || bus.w_out !== 32'h0 ||
            bus.w_idx !== 6'd0 || bus.w_last !== 1'b0 || bus.sched_we !== 1'b0 ||
            bus.sched_block !== 160'h0) begin
            errors++;
            $display("FAIL %s got ready=%b valid=%b out=%h idx=%0d last=%b we=%b blk=%h exp 1 0 0 0 0 0 0",
                     tag, bus.blk_ready, bus.w_valid, bus.w_out, bus.w_idx, bus.w_last,
                     bus.sched_we, bus.sched_block);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        check_reset_outputs("reset_values");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs("reset_release");
    endtask

    task automatic test_abc();
        logic [511:0] blk;
        logic [31:0] exp_abc [4];
        exp_abc[0] = 32'h61626380;
        exp_abc[1] = 32'h000F0000;
        exp_abc[2] = 32'h7DA86405;
        exp_abc[3] = 32'h600003C6;
        blk = {32'h61626380, 448'h0, 32'h00000018};
        drive_block(blk, 0, -1, 1'b0, -1, "abc");
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_w[16+i] !== exp_abc[i]) begin
                errors++; $display("FAIL abc_W%0d got %h exp %h", 16+i, got_w[16+i], exp_abc[i]);
            end
        end
    endtask

    task automatic test_random_stall();
        logic [511:0] blk;
        int diffs;
        for (int n = 0; n < 2; n++) begin
            blk = rand_block();
            drive_block(blk, 0, -1, 1'b0, -1, "nostall");
            for (int i = 0; i < 64; i++) saved_w[i] = got_w[i];
            drive_block(blk, 40, -1, 1'b0, -1, "stall");
            diffs = 0;
            for (int i = 0; i < 64; i++) if (got_w[i] !== saved_w[i]) diffs++;
            checks++;
            if (diffs != 0) begin
                errors++; $display("FAIL stall_stream_equal got %0d differing words exp 0", diffs);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [511:0] b1;
        logic [511:0] b2;
        b1 = rand_block();
        b2 = rand_block();
        @(negedge clk);
        bus.blk_valid = 1'b1;
        bus.blk_data  = b1;
        bus.abort     = 1'b0;
        gen_ref(b1);
        @(posedge clk);
        stream(0, -1, 1'b0, -1, 1'b1, b2, "b2b_1");
        @(negedge clk);
        #1;
        checks++;
        if (bus.w_valid !== 1'b0 || bus.blk_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_gap got valid=%b ready=%b exp 0 1", bus.w_valid, bus.blk_ready);
        end
        gen_ref(b2);
        @(posedge clk);
        stream(0, -1, 1'b0, -1, 1'b0, 512'h0, "b2b_2");
    endtask

    task automatic test_abort();
        int pts [3];
        pts[0] = 5; pts[1] = 15; pts[2] = 40;
        for (int k = 0; k < 3; k++) begin
            drive_block(rand_block(), 0, pts[k], (pts[k] == 40), -1, "abort");
            drive_block(rand_block(), 20, -1, 1'b0, -1, "post_abort");
        end
    endtask

    task automatic test_abort_idle();
        @(negedge clk);
        bus.blk_valid = 1'b1;
        bus.blk_data  = rand_block();
        bus.abort     = 1'b1;
        @(negedge clk);
        bus.blk_valid = 1'b0;
        bus.abort     = 1'b0;
        #1;
        checks++;
        if (bus.w_valid !== 1'b0 || bus.blk_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_idle got valid=%b ready=%b exp 0 1", bus.w_valid, bus.blk_ready);
        end
    endtask

    task automatic test_async_reset();
        drive_block(rand_block(), 0, -1, 1'b0, 30, "rst_run");
        bus.w_ready = 1'b1;
        #1;
        checks++;
        if (bus.w_idx !== 6'd30 || bus.w_valid !== 1'b1) begin
            errors++; $display("FAIL rst_pre got idx=%0d valid=%b exp 30 1", bus.w_idx, bus.w_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_async");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (bus.sched_we !== 1'b0) begin
                errors++; $display("FAIL rst_held_we got %b exp 0", bus.sched_we);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        bus.w_ready = 1'b0;
        #1;
        checks++;
        if (bus.blk_ready !== 1'b1 || bus.w_valid !== 1'b0) begin
            errors++; $display("FAIL rst_release got ready=%b valid=%b exp 1 0", bus.blk_ready, bus.w_valid);
        end
        drive_block(rand_block(), 30, -1, 1'b0, -1, "post_rst");
    endtask

    initial begin
        bus.blk_valid = 1'b0;
        bus.blk_data  = '0;
        bus.abort     = 1'b0;
        bus.w_ready   = 1'b0;
        test_reset();
        test_abc();
        test_random_stall();
        test_back_to_back();
        test_abort();
        test_abort_idle();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got time limit exp finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sha256_w_sched_ctrl.md
# sha256_w_sched_ctrl

Controller that sequences the SHA-256 message-schedule expansion stage. It accepts one 512-bit padded block, streams W0..W63 to the round engine under a valid/ready handshake, and drives the registered one-cycle expansion stage with `sched_we` and a 160-bit operand window. It sits between the block/padding front end and the compression rounds, and owns the 16-word history buffer that the expansion stage needs.

## Interface
- No parameters; all widths are fixed by SHA-256.
- CLK  in  1  rising-edge clock.
- RST  in  1  asynchronous, active-high reset.
- blk_valid  in  1  front end offers a block.
- blk_ready  out  1  controller can take a block; high only in IDLE.
- blk_data  in  512  block; W0 = [511:480] … W15 = [31:0].
- abort  in  1  synchronous; return to IDLE and drop the current block.
- w_valid  out  1  `w_out` holds a valid schedule word.
- w_ready  in  1  round engine accepts the word.
- w_out  out  32  current word W[t].
- w_idx  out  6  t of the current word.
- w_last  out  1  high with the word at t = 63.
- sched_we  out  1  write enable to the expansion stage.
- sched_block  out  160  {W[t+1-16], W[t+1-15], W[t+1-7], W[t+1-2], 32'h0}.
- sched_word  in  32  registered output of the expansion stage. It updates one cycle after `sched_we` and holds otherwise.

## Operation
- States:
  - IDLE: `blk_ready`=1. When `blk_valid` is high, load S[0..15]=W0..W15 and set t=0, then go to RUN.
  - RUN: `w_valid`=1. Each accept (`w_valid & w_ready`) increments t. An accept at t=63 goes to IDLE.
- History S[0..15], 32-bit each:
  - No shift while t ≤ 15.
  - On an accept with 16 ≤ t ≤ 63: S <= {S[1..15], sched_word}.
- Virtual window V[0..15]:
  - V = S when t ≤ 15.
  - V = {S[1..15], sched_word} when t ≥ 16.
  - V[k] always equals W[t-15+k].
- Word output:
  - `w_out` = S[t] when t ≤ 15, and `sched_word` when t ≥ 16.
  - In IDLE, `w_out` = 0 and `w_idx` = 0.
- Expansion issue:
  - `sched_we` = accept AND 15 ≤ t ≤ 62. This gives exactly 48 pulses per block.
  - `sched_block` = {V[0], V[1], V[9], V[14], 32'h0}, so [159:128]=W[t-15], [127:96]=W[t-14] (σ0 operand), [95:64]=W[t-6], [63:32]=W[t-1] (σ1 operand).
  - Outside issue cycles `sched_block` = 0.
  - Arithmetic and σ functions live in the expansion stage. The controller only steers operands and does no arithmetic.
- `w_last` = RUN AND t = 63.
- abort:
  - In any state, forces IDLE at the next edge. t and S are cleared and `sched_we` = 0 in that cycle.
  - abort has priority over an accept in the same cycle.
  - In IDLE, abort and `blk_valid` together: abort wins and no block is taken.
- Reset: state IDLE, t=0, S=0. All outputs read 0 except `blk_ready`, which is 1.

## Timing
- Load latency: block handshake at edge n, then W0 is valid in the cycle after edge n.
- Throughput:
  - One word per cycle while `w_ready`=1.
  - With no stalls, a block takes 64 RUN cycles plus at least 1 IDLE cycle, so 65 cycles per block.
  - No block can be accepted in the same cycle as the t=63 accept.
- Expansion pipeline:
  - An issue at the accept of t lands W[t+1] in `sched_word` at that edge, valid in the t+1 cycle.
  - W[t] needed as operand t-1 for issue t+1 is already in S or `sched_word`, so no bubble is required.
- Stall:
  - While `w_ready`=0, `w_out`, `w_idx`, `sched_word` and S hold, and `sched_we`=0.
  - The word is presented unchanged until accepted. Stall length is unbounded.
- `w_valid` never drops in RUN except through abort.
- `blk_ready` is never high in RUN.

## Test plan
- "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018), `w_ready` tied 1:
  - W16=0x61626380, W17=0x000F0000, W18=0x7DA86405, W19=0x600003C6.
  - 64 words in 64 cycles, `w_last` at w_idx=63.
  - 48 `sched_we` pulses, the first during the t=15 accept with `sched_block`[159:32]={0x61626380, 0, 0, 0}.
- Random `w_ready` (~40 % low) on random blocks:
  - The word stream is identical to the no-stall run and matches the software model.
  - `sched_we` is never high while `w_ready`=0.
- Back-to-back blocks, `blk_valid` held high:
  - Block 2 W0 appears exactly 2 cycles after the block-1 t=63 accept.
  - Block-2 words are uncorrupted by block-1 history.
- abort at t=5, at t=15 during the issue, and at t=40 with `w_ready`=0:
  - IDLE the next cycle, `w_valid`=0, `blk_ready`=1.
  - A following block produces the correct W0..W63.
- Async RST asserted mid-RUN at t=30, between clock edges:
  - Outputs go to reset values immediately; `blk_ready`=1 after release.
  - No `sched_we` pulses while RST is high.
